// File: rtl/matmul_engine.sv
// matmul_engine -- computes C = A x B, or C += A x B, using LANES parallel
// multiply-accumulate lanes. A and B are loaded element by element while the
// engine is idle. C is streamed out row-major over a valid/ready interface.
// Build option: define MATMUL_ENGINE_SATURATE_EN to clamp every accumulate to
// the DW_OUT range (signed or unsigned, matching is_signed). Without it,
// results wrap modulo 2^DW_OUT.
module matmul_engine #(
    parameter int P_M    = 4,
    parameter int P_K    = 4,
    parameter int P_N    = 4,
    parameter int DW_IN  = 8,
    parameter int LANES  = 2,
    parameter int DW_OUT = 2*DW_IN+4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [$clog2((P_M*P_K > P_K*P_N) ? P_M*P_K : P_K*P_N)-1:0] wr_addr,
    input  logic [DW_IN-1:0]    wr_data,
    input  logic                start,
    input  logic                accum,
    input  logic                is_signed,
    output logic                busy,
    output logic                done,
    output logic                c_valid,
    output logic [DW_OUT-1:0]   c_data,
    output logic                c_last,
    input  logic                c_ready
);

    localparam int NA  = P_M*P_K;
    localparam int NB  = P_K*P_N;
    localparam int NC  = P_M*P_N;
    localparam int NG  = P_N/LANES;
    localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BAW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CAW = (NC > 1) ? $clog2(NC) : 1;
    localparam int IW  = (P_M > 1) ? $clog2(P_M) : 1;
    localparam int KW  = (P_K > 1) ? $clog2(P_K) : 1;
    localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
    localparam int PW  = 2*DW_IN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        STREAM  = 2'd3
    } state_t;

    // One accumulate step. The sum is formed one bit wider so that overflow
    // can be detected for the optional clamp.
    function automatic logic [DW_OUT-1:0] f_acc_add(
        input logic [DW_OUT-1:0] a,
        input logic [DW_OUT-1:0] b,
        input logic              sgn
    );
        logic [DW_OUT:0]   s;
        logic [DW_OUT-1:0] r;
        if (sgn) begin
            s = {a[DW_OUT-1], a} + {b[DW_OUT-1], b};
        end else begin
            s = {1'b0, a} + {1'b0, b};
        end
        r = s[DW_OUT-1:0];
`ifdef MATMUL_ENGINE_SATURATE_EN
        if (sgn) begin
            if (s[DW_OUT] != s[DW_OUT-1]) begin
                r = s[DW_OUT] ? {1'b1, {(DW_OUT-1){1'b0}}} : {1'b0, {(DW_OUT-1){1'b1}}};
            end
        end else if (s[DW_OUT]) begin
            r = '1;
        end
`endif
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    logic [DW_IN-1:0]   r_a_mem [NA];
    logic [DW_IN-1:0]   r_b_mem [NB];
    logic [DW_OUT-1:0]  r_c_mem [NC];

    logic               r_accum;
    logic               r_signed;
    logic               r_done;

    // Loop counters: i outermost, then lane group, then k innermost
    logic [IW-1:0]      r_i;
    logic [GW-1:0]      r_g;
    logic [KW-1:0]      r_k;

    // Stage 1: registered products plus the tags the accumulate stage needs
    logic               r_p_valid;
    logic               r_p_first;
    logic               r_p_last;
    logic [CAW-1:0]     r_p_cbase;
    logic [DW_OUT-1:0]  r_prod [LANES];

    // Stage 2: per-lane running sums
    logic [DW_OUT-1:0]  r_acc [LANES];

    logic [CAW-1:0]     r_rd_idx;

    logic               w_last_k;
    logic               w_last_g;
    logic               w_last_i;
    logic               w_last_fetch;
    logic               w_fetch;
    logic               w_accept;
    logic               w_wr_a;
    logic               w_wr_b;
    logic               w_rd_fire;
    logic [AAW-1:0]     w_a_addr;
    logic [DW_IN-1:0]   w_a_op;
    logic [CAW-1:0]     w_c_base;

    logic [DW_OUT-1:0]  w_prod_ext [LANES];
    logic [CAW-1:0]     w_c_idx    [LANES];
    logic [DW_OUT-1:0]  w_c_old    [LANES];
    logic [DW_OUT-1:0]  w_base     [LANES];
    logic [DW_OUT-1:0]  w_sum      [LANES];

    assign w_last_k     = (r_k == KW'(P_K-1));
    assign w_last_g     = (r_g == GW'(NG-1));
    assign w_last_i     = (r_i == IW'(P_M-1));
    assign w_last_fetch = w_last_k && w_last_g && w_last_i;
    assign w_fetch      = (r_state == COMPUTE);
    assign w_accept     = (r_state == IDLE) && start;

    // Operand writes are only honoured while idle and in range
    assign w_wr_a = wr_en && !wr_sel && (r_state == IDLE) && (int'(wr_addr) < NA);
    assign w_wr_b = wr_en &&  wr_sel && (r_state == IDLE) && (int'(wr_addr) < NB);

    assign w_a_addr = AAW'(int'(r_i)*P_K + int'(r_k));
    assign w_a_op   = r_a_mem[w_a_addr];
    assign w_c_base = CAW'(int'(r_i)*P_N + int'(r_g)*LANES);

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [BAW-1:0]   w_b_addr;
        logic [DW_IN-1:0] w_b_op;
        logic [PW-1:0]    w_a_ext;
        logic [PW-1:0]    w_b_ext;
        logic [PW-1:0]    w_prod;
        logic [PW:0]      w_prod_sx;

        assign w_b_addr = BAW'(int'(r_k)*P_N + int'(r_g)*LANES + gi);
        assign w_b_op   = r_b_mem[w_b_addr];

        // Extending both operands to the product width makes the low PW bits
        // of an unsigned multiply equal to the signed product as well.
        assign w_a_ext  = {{DW_IN{r_signed & w_a_op[DW_IN-1]}}, w_a_op};
        assign w_b_ext  = {{DW_IN{r_signed & w_b_op[DW_IN-1]}}, w_b_op};
        assign w_prod   = w_a_ext * w_b_ext;

        // One extra sign bit, then a sized cast extends or trims to DW_OUT
        assign w_prod_sx      = {r_signed & w_prod[PW-1], w_prod};
        assign w_prod_ext[gi] = DW_OUT'($signed(w_prod_sx));

        assign w_c_idx[gi] = CAW'(int'(r_p_cbase) + gi);
        assign w_c_old[gi] = r_c_mem[w_c_idx[gi]];
        assign w_base[gi]  = r_p_first ? (r_accum ? w_c_old[gi] : '0) : r_acc[gi];
        assign w_sum[gi]   = f_acc_add(w_base[gi], r_prod[gi], r_signed);
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and stream outputs
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        c_valid      = 1'b0;
        c_last       = 1'b0;
        c_data       = '0;
        w_rd_fire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (w_last_fetch) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_p_valid) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                c_valid   = 1'b1;
                c_data    = r_c_mem[r_rd_idx];
                c_last    = (r_rd_idx == CAW'(NC-1));
                w_rd_fire = c_ready;
                if (c_ready && c_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign done = r_done;

    // Run mode capture, completion pulse and stream read pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_accum  <= 1'b0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            if (w_accept) begin
                r_accum  <= accum;
                r_signed <= is_signed;
            end
            r_done <= (r_state == DRAIN) && !r_p_valid;
            if (r_state != STREAM) begin
                r_rd_idx <= '0;
            end else if (w_rd_fire) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    // Fetch loop counters; they wrap back to zero after the final fetch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_i <= '0;
            r_g <= '0;
            r_k <= '0;
        end else if (w_fetch) begin
            if (w_last_k) begin
                r_k <= '0;
                if (w_last_g) begin
                    r_g <= '0;
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end else begin
                    r_g <= r_g + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else begin
            r_i <= '0;
            r_g <= '0;
            r_k <= '0;
        end
    end

    // Product stage and accumulate stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_cbase <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= '0;
                r_acc[l]  <= '0;
            end
        end else begin
            r_p_valid <= w_fetch;
            r_p_first <= (r_k == '0);
            r_p_last  <= w_last_k;
            r_p_cbase <= w_c_base;
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= w_prod_ext[l];
                if (r_p_valid) begin
                    r_acc[l] <= w_sum[l];
                end
            end
        end
    end

    // Result buffer: cleared by reset, written when a lane finishes its dot product
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < NC; n++) begin
                r_c_mem[n] <= '0;
            end
        end else if (r_p_valid && r_p_last) begin
            for (int l = 0; l < LANES; l++) begin
                r_c_mem[w_c_idx[l]] <= w_sum[l];
            end
        end
    end

    // Operand buffers; contents are kept across runs
    always_ff @(posedge clk) begin
        if (w_wr_a) begin
            r_a_mem[AAW'(wr_addr)] <= wr_data;
        end
        if (w_wr_b) begin
            r_b_mem[BAW'(wr_addr)] <= wr_data;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed testbench for matmul_engine. It uses a default instance, plus a
// second instance with DW_OUT = 16 that shares the same inputs so that
// overflow behaviour can be observed.
module tb_matmul_engine;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic        accum;
    logic        is_signed;
    logic        c_ready;

    logic        busy, done, c_valid, c_last;
    logic [19:0] c_data;
    logic        busy16, done16, c_valid16, c_last16;
    logic [15:0] c_data16;

    int n_cmp = 0;
    int n_bad = 0;

    int          done_lat;
    logic [19:0] got_main [16];
    logic [15:0] got_w16  [16];
    int          n_got, last_pos, last_cnt, stab_err, extra_done;
    logic        busy_after;

    matmul_engine u_dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .accum(accum),
        .is_signed(is_signed), .busy(busy), .done(done), .c_valid(c_valid),
        .c_data(c_data), .c_last(c_last), .c_ready(c_ready)
    );

    matmul_engine #(.DW_OUT(16)) u_dut16 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .accum(accum),
        .is_signed(is_signed), .busy(busy16), .done(done16), .c_valid(c_valid16),
        .c_data(c_data16), .c_last(c_last16), .c_ready(c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (all start and end at a negedge) ----
    task automatic write_elem(input logic sel, input int addr, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_identity_a();
        for (int e = 0; e < 16; e++) write_elem(1'b0, e, ((e / 4) == (e % 4)) ? 8'd1 : 8'd0);
    endtask

    task automatic load_ramp_b();
        for (int e = 0; e < 16; e++) write_elem(1'b1, e, 8'(e));
    endtask

    task automatic load_const(input logic sel, input logic [7:0] v);
        for (int e = 0; e < 16; e++) write_elem(sel, e, v);
    endtask

    // Pulses start and waits for done. inject_at pulses wr_en and start in that
    // compute cycle; abort_at drops rstn in that cycle and returns at once.
    task automatic start_op(input logic acc, input logic sgn, input int inject_at, input int abort_at);
        int n;
        start = 1'b1; accum = acc; is_signed = sgn;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        n = 1; done_lat = -1;
        while (n < 200) begin
            if (n == abort_at) begin
                rstn = 1'b0;
                return;
            end
            if (done === 1'b1) begin
                done_lat = n;
                break;
            end
            if (n == inject_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
                start = 1'b1; accum = 1'b1;
            end
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            n++;
        end
    endtask

    // Collects up to 16 handshaken elements. ready_mode 1 drives c_ready 1,0,0,1.
    task automatic collect_stream(input int ready_mode);
        int          cyc;
        logic        held_v;
        logic [19:0] held_d;
        n_got = 0; last_pos = -1; last_cnt = 0; stab_err = 0; extra_done = 0;
        held_v = 1'b0; held_d = '0; cyc = 0;
        while (n_got < 16 && cyc < 300) begin
            if (held_v && (c_valid !== 1'b1 || c_data !== held_d)) stab_err++;
            if (cyc > 0 && done === 1'b1) extra_done++;
            c_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            if (c_valid === 1'b1 && c_ready) begin
                got_main[n_got] = c_data;
                got_w16[n_got]  = c_data16;
                if (c_last === 1'b1) begin
                    last_cnt++;
                    last_pos = n_got;
                end
                n_got++;
                held_v = 1'b0;
            end else if (c_valid === 1'b1) begin
                held_v = 1'b1;
                held_d = c_data;
            end else begin
                held_v = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        c_ready = 1'b0;
        busy_after = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        if ({busy, done, c_valid, c_last} !== 4'b0000 || c_data !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got busy/done/valid/last=%b data=%0d required 0000 and 0",
                     {busy, done, c_valid, c_last}, c_data);
        end
        n_cmp++;
        rstn = 1'b1;
        @(negedge clk);
        if (busy !== 1'b0 || c_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle got busy=%b c_valid=%b required 0 0", busy, c_valid);
        end
        n_cmp++;
        $display("test_reset done");
    endtask

    task automatic test_identity();
        load_identity_a();
        load_ramp_b();
        start_op(1'b0, 1'b0, 0, 0);
        if (done_lat !== 35) begin
            n_bad++; $display("FAIL identity_latency got %0d required 35", done_lat);
        end
        n_cmp++;
        collect_stream(0);
        if (n_got !== 16) begin
            n_bad++; $display("FAIL identity_count got %0d required 16", n_got);
        end
        n_cmp++;
        for (int e = 0; e < 16; e++) begin
            if (got_main[e] !== 20'(e)) begin
                n_bad++; $display("FAIL identity_c[%0d] got %0d required %0d", e, got_main[e], e);
            end
            n_cmp++;
        end
        if (last_pos !== 15 || last_cnt !== 1) begin
            n_bad++; $display("FAIL identity_last got pos=%0d cnt=%0d required 15 1", last_pos, last_cnt);
        end
        n_cmp++;
        if (busy_after !== 1'b0 || extra_done !== 0) begin
            n_bad++; $display("FAIL identity_end got busy=%b extra_done=%0d required 0 0", busy_after, extra_done);
        end
        n_cmp++;
        $display("test_identity done latency=%0d", done_lat);
    endtask

    task automatic test_accum();
        start_op(1'b1, 1'b0, 0, 0);
        if (done_lat !== 35) begin
            n_bad++; $display("FAIL accum_latency got %0d required 35", done_lat);
        end
        n_cmp++;
        collect_stream(0);
        for (int e = 0; e < 16; e++) begin
            if (got_main[e] !== 20'(2*e)) begin
                n_bad++; $display("FAIL accum_c[%0d] got %0d required %0d", e, got_main[e], 2*e);
            end
            n_cmp++;
        end
        $display("test_accum done");
    endtask

    task automatic test_backpressure();
        start_op(1'b0, 1'b0, 5, 0);
        if (done_lat !== 35) begin
            n_bad++; $display("FAIL bp_latency got %0d required 35", done_lat);
        end
        n_cmp++;
        collect_stream(1);
        if (n_got !== 16 || stab_err !== 0 || last_pos !== 15 || last_cnt !== 1) begin
            n_bad++;
            $display("FAIL bp_stream got count=%0d unstable=%0d lastpos=%0d lastcnt=%0d required 16 0 15 1",
                     n_got, stab_err, last_pos, last_cnt);
        end
        n_cmp++;
        for (int e = 0; e < 16; e++) begin
            if (got_main[e] !== 20'(e)) begin
                n_bad++; $display("FAIL bp_c[%0d] got %0d required %0d", e, got_main[e], e);
            end
            n_cmp++;
        end
        $display("test_backpressure done");
    endtask

    task automatic test_signed();
        logic [19:0] exp_v;
        load_const(1'b0, 8'h80);
        load_const(1'b1, 8'h80);
        start_op(1'b0, 1'b1, 0, 0);
        collect_stream(0);
        for (int e = 0; e < 16; e += 5) begin
            if (got_main[e] !== 20'd65536) begin
                n_bad++; $display("FAIL signed_m128_c[%0d] got %0d required 65536", e, got_main[e]);
            end
            n_cmp++;
        end
        start_op(1'b0, 1'b0, 0, 0);
        collect_stream(0);
        for (int e = 0; e < 16; e += 5) begin
            if (got_main[e] !== 20'd65536) begin
                n_bad++; $display("FAIL unsigned_80_c[%0d] got %0d required 65536", e, got_main[e]);
            end
            n_cmp++;
        end
        // A all 0xFF against the ramp: column sums of B are 24 + 4j
        load_const(1'b0, 8'hFF);
        load_ramp_b();
        start_op(1'b0, 1'b1, 0, 0);
        collect_stream(0);
        for (int e = 0; e < 16; e += 3) begin
            exp_v = 20'(1048576 - (24 + 4*(e % 4)));
            if (got_main[e] !== exp_v) begin
                n_bad++; $display("FAIL signed_neg_c[%0d] got %0d required %0d", e, got_main[e], exp_v);
            end
            n_cmp++;
        end
        start_op(1'b0, 1'b0, 0, 0);
        collect_stream(0);
        for (int e = 0; e < 16; e += 3) begin
            exp_v = 20'(255 * (24 + 4*(e % 4)));
            if (got_main[e] !== exp_v) begin
                n_bad++; $display("FAIL unsigned_ff_c[%0d] got %0d required %0d", e, got_main[e], exp_v);
            end
            n_cmp++;
        end
        $display("test_signed done");
    endtask

    task automatic test_overflow();
        logic [15:0] exp16;
`ifdef MATMUL_ENGINE_SATURATE_EN
        exp16 = 16'd65535;
`else
        exp16 = 16'd63492;
`endif
        load_const(1'b0, 8'hFF);
        for (int e = 0; e < 15; e++) write_elem(1'b1, e, 8'hFF);
        // The final operand write lands in the same cycle as start
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd15; wr_data = 8'hFF;
        start_op(1'b0, 1'b0, 0, 0);
        if (done_lat !== 35) begin
            n_bad++; $display("FAIL ovf_latency got %0d required 35", done_lat);
        end
        n_cmp++;
        collect_stream(0);
        for (int e = 0; e < 16; e += 3) begin
            if (got_main[e] !== 20'd260100) begin
                n_bad++; $display("FAIL ovf_wide_c[%0d] got %0d required 260100", e, got_main[e]);
            end
            n_cmp++;
            if (got_w16[e] !== exp16) begin
                n_bad++; $display("FAIL ovf_w16_c[%0d] got %0d required %0d", e, got_w16[e], exp16);
            end
            n_cmp++;
        end
        $display("test_overflow done");
    endtask

    task automatic test_reset_abort();
        int stray;
        load_identity_a();
        load_ramp_b();
        start_op(1'b0, 1'b0, 0, 10);
        #1;
        if (busy !== 1'b0 || c_valid !== 1'b0 || done !== 1'b0 || c_data !== 20'd0) begin
            n_bad++;
            $display("FAIL abort_immediate got busy=%b c_valid=%b done=%b data=%0d required 0 0 0 0",
                     busy, c_valid, done, c_data);
        end
        n_cmp++;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        stray = 0;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1 || c_valid === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        if (stray !== 0) begin
            n_bad++; $display("FAIL abort_quiet got %0d active cycles required 0", stray);
        end
        n_cmp++;
        load_identity_a();
        load_ramp_b();
        start_op(1'b1, 1'b0, 0, 0);
        collect_stream(0);
        for (int e = 0; e < 16; e++) begin
            if (got_main[e] !== 20'(e)) begin
                n_bad++; $display("FAIL abort_rerun_c[%0d] got %0d required %0d", e, got_main[e], e);
            end
            n_cmp++;
        end
        $display("test_reset_abort done");
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; accum = 1'b0; is_signed = 1'b0; c_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_identity();
        test_accum();
        test_backpressure();
        test_signed();
        test_overflow();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
